div_seq_param: RTL

Parametrised sequential restoring divider for the calculator datapath. It replaces the fixed 16-bit shift/subtract divider register slice with a self-contained unit that has integrated control, a start/done handshake, signed or unsigned operation, a remainder output and divide-by-zero detection. It sits between the operand registers and the result multiplexer of the calculator core. It retires one quotient bit per clock.

---
 rtl/div_seq_param.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/div_seq_param.sv
// -----------------------------------------------------------------------------
// div_seq_param
//
// Sequential restoring divider with integrated control. Retires one quotient
// bit per clock. Supports unsigned and (optionally) two's-complement operation,
// produces quotient and remainder, and flags divide-by-zero.
//
// Parameters:
//   WIDTH     - operand / quotient / remainder width (4..32)
//   SIGNED_EN - 0 removes the signed path; i_signed is then ignored
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - asynchronous active-high reset
//   i_start  - start request, sampled only when idle
//   i_signed - two's-complement mode, sampled with i_start
//   i_dvd    - dividend, sampled with i_start
//   i_dvs    - divisor, sampled with i_start
//   o_busy   - high while an operation is in progress
//   o_done   - one-cycle completion pulse; results valid from this cycle
//   o_q      - quotient, held until the next completion
//   o_rem    - remainder, held until the next completion
//   o_div0   - divide-by-zero flag for the last result
// -----------------------------------------------------------------------------
module div_seq_param #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_dvs,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_div0
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH:0]   r_a;      // partial remainder
    logic [WIDTH-1:0] r_m;      // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] r_dvs;    // divisor magnitude
    logic [CW-1:0]    r_cnt;
    logic             r_qs;
    logic             r_rs;
    logic             r_dz;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic             r_div0;
    logic             r_done;

    logic             w_sgn_mode;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;
    logic [WIDTH+1:0] w_a_sh;
    logic [WIDTH+1:0] w_trial;
    logic             w_trial_ok;
    logic             w_cnt_last;
    logic [WIDTH-1:0] w_a_low;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_rem_fix;

    always_comb begin
        w_sgn_mode = SIGNED_EN && i_signed;
        w_dvd_neg  = w_sgn_mode && i_dvd[WIDTH-1];
        w_dvs_neg  = w_sgn_mode && i_dvs[WIDTH-1];
        // -(2^(WIDTH-1)) wraps to itself, which is the correct unsigned magnitude
        w_dvd_mag  = w_dvd_neg ? -i_dvd : i_dvd;
        w_dvs_mag  = w_dvs_neg ? -i_dvs : i_dvs;
        w_dvs_zero = (i_dvs == '0);

        // {A,M} << 1; the extra top bit keeps the trial sign intact
        w_a_sh     = {r_a, r_m[WIDTH-1]};
        w_trial    = w_a_sh - {2'b00, r_dvs};
        w_trial_ok = ~w_trial[WIDTH+1];
        w_cnt_last = (r_cnt == CW'(WIDTH - 1));

        w_a_low    = r_a[WIDTH-1:0];
        w_q_fix    = r_qs ? -r_m : r_m;
        w_rem_fix  = r_rs ? -w_a_low : w_a_low;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_m     <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_qs    <= 1'b0;
            r_rs    <= 1'b0;
            r_dz    <= 1'b0;
            r_q     <= '0;
            r_rem   <= '0;
            r_div0  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a   <= '0;
                        r_cnt <= '0;
                        r_qs  <= w_dvd_neg ^ w_dvs_neg;
                        r_rs  <= w_dvd_neg;
                        r_dvs <= w_dvs_mag;
                        r_dz  <= w_dvs_zero;
                        if (w_dvs_zero) begin
                            // keep the raw dividend so it can be returned as REM
                            r_m     <= i_dvd;
                            r_state <= S_FIX;
                        end else begin
                            r_m     <= w_dvd_mag;
                            r_state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    if (w_trial_ok) begin
                        r_a <= w_trial[WIDTH:0];
                        r_m <= {r_m[WIDTH-2:0], 1'b1};
                    end else begin
                        r_a <= w_a_sh[WIDTH:0];
                        r_m <= {r_m[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (w_cnt_last) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (r_dz) begin
                        r_q    <= '1;
                        r_rem  <= r_m;
                        r_div0 <= 1'b1;
                    end else begin
                        r_q    <= w_q_fix;
                        r_rem  <= w_rem_fix;
                        r_div0 <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_q    = r_q;
    assign o_rem  = r_rem;
    assign o_div0 = r_div0;

endmodule
